// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl
// Brief    : Decodes UART RX byte frames into register-file / ALU commands
//            and returns read data or ALU results as bytes to the TX FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ALU_W      = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_ERR,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    input  logic [DATA_WIDTH-1:0] RF_RdData,
    input  logic                  RF_RdData_VLD,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  CLK_GATE_EN,
    input  logic [ALU_W-1:0]      ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  FIFO_FULL,
    output logic                  CMD_ERR
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_WR_ADDR  = 4'd1;
    localparam logic [3:0] c_WR_DATA  = 4'd2;
    localparam logic [3:0] c_RD_ADDR  = 4'd3;
    localparam logic [3:0] c_RD_WAIT  = 4'd4;
    localparam logic [3:0] c_ALU_A    = 4'd5;
    localparam logic [3:0] c_ALU_B    = 4'd6;
    localparam logic [3:0] c_ALU_FUN  = 4'd7;
    localparam logic [3:0] c_ALU_WAIT = 4'd8;
    localparam logic [3:0] c_TX_BYTE  = 4'd9;
    localparam logic [3:0] c_TX_LO    = 4'd10;
    localparam logic [3:0] c_TX_HI    = 4'd11;

    localparam logic [DATA_WIDTH-1:0] c_OP_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] c_OP_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] c_OP_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] c_OP_FUN = DATA_WIDTH'(8'hDD);

    localparam logic [ADDR_WIDTH-1:0] c_OPA_ADDR = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] c_OPB_ADDR = ADDR_WIDTH'(1);

    logic [3:0]            r_state,       w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,        w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_data,        w_data_nxt;
    logic [ALU_W-1:0]      r_result,      w_result_nxt;
    logic [c_CNT_W-1:0]    r_cnt,         w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_rf_addr,     w_rf_addr_nxt;
    logic                  r_rf_wr_en,    w_rf_wr_en_nxt;
    logic                  r_rf_rd_en,    w_rf_rd_en_nxt;
    logic [DATA_WIDTH-1:0] r_rf_wr_data,  w_rf_wr_data_nxt;
    logic                  r_alu_en,      w_alu_en_nxt;
    logic [3:0]            r_alu_fun,     w_alu_fun_nxt;
    logic                  r_clk_gate_en, w_clk_gate_en_nxt;
    logic [DATA_WIDTH-1:0] r_tx_data,     w_tx_data_nxt;
    logic                  r_tx_vld,      w_tx_vld_nxt;
    logic                  r_cmd_err,     w_cmd_err_nxt;

    logic w_byte_ok;
    logic w_byte_err;
    logic w_operand_st;

    assign w_byte_ok    = RX_D_VLD && !RX_ERR;
    assign w_byte_err   = RX_D_VLD &&  RX_ERR;
    assign w_operand_st = (r_state == c_WR_ADDR) || (r_state == c_WR_DATA) ||
                          (r_state == c_RD_ADDR) || (r_state == c_ALU_A)   ||
                          (r_state == c_ALU_B)   || (r_state == c_ALU_FUN);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= c_IDLE;
            r_addr        <= '0;
            r_data        <= '0;
            r_result      <= '0;
            r_cnt         <= '0;
            r_rf_addr     <= '0;
            r_rf_wr_en    <= 1'b0;
            r_rf_rd_en    <= 1'b0;
            r_rf_wr_data  <= '0;
            r_alu_en      <= 1'b0;
            r_alu_fun     <= '0;
            r_clk_gate_en <= 1'b0;
            r_tx_data     <= '0;
            r_tx_vld      <= 1'b0;
            r_cmd_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_data        <= w_data_nxt;
            r_result      <= w_result_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rf_addr     <= w_rf_addr_nxt;
            r_rf_wr_en    <= w_rf_wr_en_nxt;
            r_rf_rd_en    <= w_rf_rd_en_nxt;
            r_rf_wr_data  <= w_rf_wr_data_nxt;
            r_alu_en      <= w_alu_en_nxt;
            r_alu_fun     <= w_alu_fun_nxt;
            r_clk_gate_en <= w_clk_gate_en_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_tx_vld      <= w_tx_vld_nxt;
            r_cmd_err     <= w_cmd_err_nxt;
        end
    end

    // Output registers are loaded from next-state values so every strobe
    // lands exactly one cycle after the byte or valid that caused it.
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_data_nxt       = r_data;
        w_result_nxt     = r_result;
        w_cnt_nxt        = '0;
        w_rf_addr_nxt    = r_rf_addr;
        w_rf_wr_en_nxt   = 1'b0;
        w_rf_rd_en_nxt   = 1'b0;
        w_rf_wr_data_nxt = r_rf_wr_data;
        w_alu_en_nxt     = 1'b0;
        w_alu_fun_nxt    = r_alu_fun;
        w_tx_data_nxt    = r_tx_data;
        w_tx_vld_nxt     = 1'b0;
        w_cmd_err_nxt    = 1'b0;

        if (w_operand_st && w_byte_err) begin
            w_state_nxt   = c_IDLE;
            w_cmd_err_nxt = 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_byte_ok) begin
                        if (RX_P_DATA == c_OP_WR) begin
                            w_state_nxt = c_WR_ADDR;
                        end else if (RX_P_DATA == c_OP_RD) begin
                            w_state_nxt = c_RD_ADDR;
                        end else if (RX_P_DATA == c_OP_ALU) begin
                            w_state_nxt = c_ALU_A;
                        end else if (RX_P_DATA == c_OP_FUN) begin
                            w_state_nxt = c_ALU_FUN;
                        end
                    end
                end
                c_WR_ADDR: begin
                    if (w_byte_ok) begin
                        w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                        w_state_nxt = c_WR_DATA;
                    end
                end
                c_WR_DATA: begin
                    if (w_byte_ok) begin
                        w_rf_wr_en_nxt   = 1'b1;
                        w_rf_addr_nxt    = r_addr;
                        w_rf_wr_data_nxt = RX_P_DATA;
                        w_state_nxt      = c_IDLE;
                    end
                end
                c_RD_ADDR: begin
                    if (w_byte_ok) begin
                        w_rf_rd_en_nxt = 1'b1;
                        w_rf_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                        w_addr_nxt     = RX_P_DATA[ADDR_WIDTH-1:0];
                        w_state_nxt    = c_RD_WAIT;
                    end
                end
                c_RD_WAIT: begin
                    if (RF_RdData_VLD) begin
                        w_data_nxt  = RF_RdData;
                        w_state_nxt = c_TX_BYTE;
                    end else if (r_cnt == c_TIMEOUT) begin
                        w_cmd_err_nxt = 1'b1;
                        w_state_nxt   = c_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                c_ALU_A: begin
                    if (w_byte_ok) begin
                        w_rf_wr_en_nxt   = 1'b1;
                        w_rf_addr_nxt    = c_OPA_ADDR;
                        w_rf_wr_data_nxt = RX_P_DATA;
                        w_state_nxt      = c_ALU_B;
                    end
                end
                c_ALU_B: begin
                    if (w_byte_ok) begin
                        w_rf_wr_en_nxt   = 1'b1;
                        w_rf_addr_nxt    = c_OPB_ADDR;
                        w_rf_wr_data_nxt = RX_P_DATA;
                        w_state_nxt      = c_ALU_FUN;
                    end
                end
                c_ALU_FUN: begin
                    if (w_byte_ok) begin
                        w_alu_en_nxt  = 1'b1;
                        w_alu_fun_nxt = RX_P_DATA[3:0];
                        w_state_nxt   = c_ALU_WAIT;
                    end
                end
                c_ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        w_result_nxt = ALU_OUT;
                        w_state_nxt  = c_TX_LO;
                    end else if (r_cnt == c_TIMEOUT) begin
                        w_cmd_err_nxt = 1'b1;
                        w_state_nxt   = c_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                c_TX_BYTE: begin
                    if (!FIFO_FULL) begin
                        w_tx_vld_nxt  = 1'b1;
                        w_tx_data_nxt = r_data;
                        w_state_nxt   = c_IDLE;
                    end
                end
                c_TX_LO: begin
                    if (!FIFO_FULL) begin
                        w_tx_vld_nxt  = 1'b1;
                        w_tx_data_nxt = r_result[DATA_WIDTH-1:0];
                        w_state_nxt   = c_TX_HI;
                    end
                end
                c_TX_HI: begin
                    if (!FIFO_FULL) begin
                        w_tx_vld_nxt  = 1'b1;
                        w_tx_data_nxt = r_result[2*DATA_WIDTH-1:DATA_WIDTH];
                        w_state_nxt   = c_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end

        w_clk_gate_en_nxt = (w_state_nxt == c_ALU_FUN) || (w_state_nxt == c_ALU_WAIT);
    end

    assign RF_Address  = r_rf_addr;
    assign RF_WrEn     = r_rf_wr_en;
    assign RF_RdEn     = r_rf_rd_en;
    assign RF_WrData   = r_rf_wr_data;
    assign ALU_EN      = r_alu_en;
    assign ALU_FUN     = r_alu_fun;
    assign CLK_GATE_EN = r_clk_gate_en;
    assign TX_P_DATA   = r_tx_data;
    assign TX_D_VLD    = r_tx_vld;
    assign CMD_ERR     = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_ctrl
// Brief    : Scoreboard bench for uart_cmd_ctrl frame decoding and TX return.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int AL = 16;
    localparam int TO = 255;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] RX_P_DATA = '0;
    logic          RX_D_VLD = 1'b0;
    logic          RX_ERR = 1'b0;
    logic [AW-1:0] RF_Address;
    logic          RF_WrEn;
    logic          RF_RdEn;
    logic [DW-1:0] RF_WrData;
    logic [DW-1:0] RF_RdData = '0;
    logic          RF_RdData_VLD = 1'b0;
    logic          ALU_EN;
    logic [3:0]    ALU_FUN;
    logic          CLK_GATE_EN;
    logic [AL-1:0] ALU_OUT = '0;
    logic          ALU_OUT_VLD = 1'b0;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_D_VLD;
    logic          FIFO_FULL = 1'b0;
    logic          CMD_ERR;

    logic [29:0]   all_out;
    assign all_out = {RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN,
                      CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR};

    always #5 CLK = ~CLK;

    uart_cmd_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ALU_W      (AL),
        .TIMEOUT    (TO)
    ) u_dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_P_DATA     (RX_P_DATA),
        .RX_D_VLD      (RX_D_VLD),
        .RX_ERR        (RX_ERR),
        .RF_Address    (RF_Address),
        .RF_WrEn       (RF_WrEn),
        .RF_RdEn       (RF_RdEn),
        .RF_WrData     (RF_WrData),
        .RF_RdData     (RF_RdData),
        .RF_RdData_VLD (RF_RdData_VLD),
        .ALU_EN        (ALU_EN),
        .ALU_FUN       (ALU_FUN),
        .CLK_GATE_EN   (CLK_GATE_EN),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VLD   (ALU_OUT_VLD),
        .TX_P_DATA     (TX_P_DATA),
        .TX_D_VLD      (TX_D_VLD),
        .FIFO_FULL     (FIFO_FULL),
        .CMD_ERR       (CMD_ERR)
    );

    int n_total = 0;
    int n_bad   = 0;
    int tx_seen = 0;
    int err_exp = 0;

    logic [11:0] q_wr[$];   // {addr, data}
    logic [3:0]  q_rd[$];   // read address
    logic [4:0]  q_alu[$];  // {clk gate, function}
    logic [7:0]  q_tx[$];   // bytes to the FIFO, in order

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RF_WrEn) begin
            if (q_wr.size() == 0) chk("wr_extra", 32'(RF_WrEn), 32'd0);
            else chk("rf_wr", 32'({RF_Address, RF_WrData}), 32'(q_wr.pop_front()));
        end
        if (RF_RdEn) begin
            if (q_rd.size() == 0) chk("rd_extra", 32'(RF_RdEn), 32'd0);
            else chk("rf_rd", 32'(RF_Address), 32'(q_rd.pop_front()));
        end
        if (ALU_EN) begin
            if (q_alu.size() == 0) chk("alu_extra", 32'(ALU_EN), 32'd0);
            else chk("alu_en", 32'({CLK_GATE_EN, ALU_FUN}), 32'(q_alu.pop_front()));
        end
        if (TX_D_VLD) begin
            tx_seen++;
            if (q_tx.size() == 0) chk("tx_extra", 32'(TX_D_VLD), 32'd0);
            else chk("tx_byte", 32'(TX_P_DATA), 32'(q_tx.pop_front()));
        end
        if (CMD_ERR) begin
            if (err_exp == 0) chk("err_extra", 32'(CMD_ERR), 32'd0);
            else err_exp--;
        end
    end

    task automatic send(input logic [7:0] b, input logic err);
        @(posedge CLK); #1;
        RX_P_DATA = b;
        RX_ERR    = err;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
        RX_ERR    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // which: 0 = RF_RdEn, 1 = ALU_EN, otherwise CMD_ERR
    task automatic wait_for(input int which, input int max_cyc, input string tag, output int cyc);
        logic hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < max_cyc) begin
            @(negedge CLK);
            cyc++;
            case (which)
                0:       hit = RF_RdEn;
                1:       hit = ALU_EN;
                default: hit = CMD_ERR;
            endcase
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    task automatic drain(input string tag);
        chk({tag, "_wr_left"},  32'(q_wr.size()),  32'd0);
        chk({tag, "_rd_left"},  32'(q_rd.size()),  32'd0);
        chk({tag, "_alu_left"}, 32'(q_alu.size()), 32'd0);
        chk({tag, "_tx_left"},  32'(q_tx.size()),  32'd0);
        chk({tag, "_err_left"}, 32'(err_exp),      32'd0);
    endtask

    task automatic alu_result(input logic [15:0] v);
        repeat (2) @(posedge CLK);
        #1;
        ALU_OUT     = v;
        ALU_OUT_VLD = 1'b1;
        @(posedge CLK); #1;
        ALU_OUT_VLD = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int s;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", 32'(all_out), 32'd0);
        RST = 1'b1;
        idle(2);

        // register write
        q_wr.push_back({4'h5, 8'h3C});
        send(8'hAA, 1'b0);
        send(8'h05, 1'b0);
        send(8'h3C, 1'b0);
        idle(5);
        drain("write");

        // register read, data returned two cycles after the strobe
        q_rd.push_back(4'h5);
        q_tx.push_back(8'h3C);
        send(8'hBB, 1'b0);
        send(8'h05, 1'b0);
        wait_for(0, 20, "read_rden", c);
        repeat (2) @(posedge CLK);
        #1;
        RF_RdData = 8'h3C;
        RF_RdData_VLD = 1'b1;
        @(posedge CLK); #1;
        RF_RdData_VLD = 1'b0;
        idle(5);
        drain("read");

        // full ALU frame with operands
        q_wr.push_back({4'h0, 8'h0A});
        q_wr.push_back({4'h1, 8'h03});
        q_alu.push_back({1'b1, 4'h0});
        q_tx.push_back(8'h0D);
        q_tx.push_back(8'h00);
        send(8'hCC, 1'b0);
        send(8'h0A, 1'b0);
        send(8'h03, 1'b0);
        send(8'h00, 1'b0);
        wait_for(1, 20, "alu_start", c);
        alu_result(16'h000D);
        idle(6);
        chk("gate_off_after_alu", 32'(CLK_GATE_EN), 32'd0);
        drain("alu");

        // FIFO backpressure in TX_LO
        q_alu.push_back({1'b1, 4'h2});
        q_tx.push_back(8'h34);
        q_tx.push_back(8'h12);
        send(8'hDD, 1'b0);
        send(8'h02, 1'b0);
        wait_for(1, 20, "bp_alu_start", c);
        FIFO_FULL = 1'b1;
        alu_result(16'h1234);
        s = tx_seen;
        repeat (10) @(posedge CLK);
        #1;
        chk("bp_hold", 32'(tx_seen - s), 32'd0);
        FIFO_FULL = 1'b0;
        idle(6);
        chk("bp_both_bytes", 32'(tx_seen - s), 32'd2);
        drain("backpressure");

        // RX_ERR on an operand byte aborts the frame
        err_exp = 1;
        send(8'hAA, 1'b0);
        send(8'h05, 1'b1);
        idle(5);
        drain("rx_err_operand");

        // RX_ERR on an opcode in IDLE is ignored, as are non-opcode bytes
        send(8'hAA, 1'b1);
        send(8'h05, 1'b0);
        send(8'h3C, 1'b0);
        send(8'h12, 1'b0);
        idle(5);
        drain("rx_err_idle");

        // read timeout
        q_rd.push_back(4'h2);
        err_exp = 1;
        send(8'hBB, 1'b0);
        send(8'h02, 1'b0);
        wait_for(0, 20, "to_rden", c);
        wait_for(2, 400, "to_cmd_err", c);
        chk("to_latency", 32'(c), 32'(TO + 1));
        idle(5);
        drain("timeout");

        // valid on the expiry cycle wins; a byte arriving during the wait is dropped
        q_rd.push_back(4'h7);
        q_tx.push_back(8'h5A);
        send(8'hBB, 1'b0);
        send(8'h07, 1'b0);
        wait_for(0, 20, "edge_rden", c);
        @(posedge CLK); #1;
        RX_P_DATA = 8'hAA;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
        repeat (TO - 2) @(posedge CLK);
        #1;
        RF_RdData     = 8'h5A;
        RF_RdData_VLD = 1'b1;
        @(posedge CLK); #1;
        RF_RdData_VLD = 1'b0;
        idle(5);
        drain("expiry_edge");

        // asynchronous reset while waiting on the ALU
        q_alu.push_back({1'b1, 4'h3});
        send(8'hDD, 1'b0);
        send(8'h03, 1'b0);
        wait_for(1, 20, "rst_alu_start", c);
        #2;
        RST = 1'b0;
        #1;
        chk("reset_async_outputs", 32'(all_out), 32'd0);
        idle(2);
        RST = 1'b1;
        alu_result(16'hBEEF);
        idle(3);
        q_wr.push_back({4'h9, 8'h77});
        send(8'hAA, 1'b0);
        send(8'h09, 1'b0);
        send(8'h77, 1'b0);
        idle(5);
        drain("after_reset");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
